// File: rtl/datapath_sequencer.sv
// Phase sequencer for the LEGv8 datapath: one-hot phase enables, stall, halt, instruction limit, retired count.
// Latency: outputs are a combinational decode of registered state and stall; first phase_en[0] is one cycle after start.
// Backpressure: stall freezes the active phase and suppresses all enables. Optional SEQ_PERF_COUNTERS_EN adds stall_cycles.
module datapath_sequencer #(
    parameter int WORD       = 64,
    parameter int NUM_PHASES = 5,
    parameter int MAX_INSTR  = 20
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  stall,
    input  logic                  halt_req,
    output logic [NUM_PHASES-1:0] phase_en,
    output logic                  pc_write_en,
    output logic [WORD-1:0]       instr_count,
    output logic                  busy,
`ifdef SEQ_PERF_COUNTERS_EN
    output logic [WORD-1:0]       stall_cycles,
`endif
    output logic                  done
);

    // NUM_PHASES is legal in 2..16, so the phase index is 1..4 bits wide
    localparam int PW = $clog2(NUM_PHASES);
    localparam logic [PW-1:0]   LAST_PHASE = PW'(NUM_PHASES - 1);
    localparam logic [WORD-1:0] MAX_W      = WORD'(MAX_INSTR);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   phase_idx_q, phase_idx_d;
    logic            halt_pending_q, halt_pending_d;
    logic [WORD-1:0] instr_count_q, instr_count_d;

    logic running;
    logic advance;
    logic commit;
    logic limit_hit;
    logic restart;

    assign running   = (state_q == S_RUN);
    assign advance   = running && !stall;
    assign commit    = advance && (phase_idx_q == LAST_PHASE);
    assign restart   = ((state_q == S_IDLE) || (state_q == S_DONE)) && start;
    // Limit compares against the count this commit produces, so MAX_INSTR commits retire before stopping
    assign limit_hit = (MAX_INSTR != 0) && ((instr_count_q + WORD'(1)) == MAX_W);

    assign phase_en    = advance ? (NUM_PHASES'(1) << phase_idx_q) : '0;
    assign pc_write_en = phase_en[NUM_PHASES-1];
    assign instr_count = instr_count_q;
    assign busy        = running;
    assign done        = (state_q == S_DONE);

    // Next-state logic: start/restart, phase stepping, commit, and halt/limit termination
    always_comb begin
        state_d        = state_q;
        phase_idx_d    = phase_idx_q;
        halt_pending_d = halt_pending_q;
        instr_count_d  = instr_count_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d        = S_RUN;
                    phase_idx_d    = '0;
                    halt_pending_d = 1'b0;
                    instr_count_d  = '0;
                end
            end
            S_RUN: begin
                if (commit) begin
                    instr_count_d = instr_count_q + WORD'(1);
                    phase_idx_d   = '0;
                    if (halt_pending_q || halt_req || limit_hit) begin
                        state_d        = S_DONE;
                        halt_pending_d = 1'b0;
                    end
                end else begin
                    // Any non-commit RUN cycle, stalled or not, latches a halt request
                    halt_pending_d = halt_pending_q | halt_req;
                    if (!stall) begin
                        phase_idx_d = phase_idx_q + PW'(1);
                    end
                end
            end
            default: begin
                state_d        = S_IDLE;
                phase_idx_d    = '0;
                halt_pending_d = 1'b0;
                instr_count_d  = '0;
            end
        endcase
    end

    // Sequencer state registers; reset aborts any in-flight instruction without a commit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            phase_idx_q    <= '0;
            halt_pending_q <= 1'b0;
            instr_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            phase_idx_q    <= phase_idx_d;
            halt_pending_q <= halt_pending_d;
            instr_count_q  <= instr_count_d;
        end
    end

`ifdef SEQ_PERF_COUNTERS_EN
    logic [WORD-1:0] stall_cycles_q;

    assign stall_cycles = stall_cycles_q;

    // Saturating count of stalled RUN cycles, cleared on every start
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles_q <= '0;
        end else if (restart) begin
            stall_cycles_q <= '0;
        end else if (running && stall && !(&stall_cycles_q)) begin
            stall_cycles_q <= stall_cycles_q + WORD'(1);
        end
    end
`else
    logic unused_restart;
    assign unused_restart = restart;
`endif

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer with NUM_PHASES=5, MAX_INSTR=3.
// Inputs driven 2ns after the rising edge; outputs sampled 1ns later.
// Covers run-to-limit, restart, stall, stall on commit, halt and mid-run reset.
module tb_datapath_sequencer;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        stall;
    logic        halt_req;
    logic [4:0]  phase_en;
    logic        pc_write_en;
    logic [63:0] instr_count;
    logic        busy;
    logic        done;
`ifdef SEQ_PERF_COUNTERS_EN
    logic [63:0] stall_cycles;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    datapath_sequencer #(
        .WORD       (64),
        .NUM_PHASES (5),
        .MAX_INSTR  (3)
    ) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .stall       (stall),
        .halt_req    (halt_req),
        .phase_en    (phase_en),
        .pc_write_en (pc_write_en),
        .instr_count (instr_count),
        .busy        (busy),
`ifdef SEQ_PERF_COUNTERS_EN
        .stall_cycles(stall_cycles),
`endif
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to the next cycle and settle just after the edge so new inputs can be applied
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
        #1;
    endtask

    logic [4:0] one5;
    logic [4:0] exp_pe;

    initial begin
        one5     = 5'd1;
        reset_n  = 1'b0;
        start    = 1'b0;
        stall    = 1'b0;
        halt_req = 1'b0;
        #1;
        check_eq("rst_phase_en", 64'(phase_en), 64'd0);
        check_eq("rst_pc_we", 64'(pc_write_en), 64'd0);
        check_eq("rst_count", instr_count, 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        #20;
        reset_n = 1'b1;
        step();
        step();
        check_eq("idle_busy", 64'(busy), 64'd0);

        // Run to limit: three instructions, commits at cycles 5,10,15, DONE at 16
        pulse_start();
        for (int c = 1; c <= 16; c++) begin
            if (c <= 15) begin
                exp_pe = one5 << ((c - 1) % 5);
                check_eq($sformatf("lim_pe_c%0d", c), 64'(phase_en), 64'(exp_pe));
                check_eq($sformatf("lim_pc_c%0d", c), 64'(pc_write_en), ((c % 5) == 0) ? 64'd1 : 64'd0);
                check_eq($sformatf("lim_cnt_c%0d", c), instr_count, 64'((c - 1) / 5));
                check_eq($sformatf("lim_busy_c%0d", c), 64'(busy), 64'd1);
            end else begin
                check_eq("lim_done", 64'(done), 64'd1);
                check_eq("lim_busy_end", 64'(busy), 64'd0);
                check_eq("lim_cnt_end", instr_count, 64'd3);
                check_eq("lim_pe_end", 64'(phase_en), 64'd0);
            end
            step();
            #1;
        end
        check_eq("lim_done_hold", 64'(done), 64'd1);
        check_eq("lim_cnt_hold", instr_count, 64'd3);

        // Restart from DONE, then stall 4 cycles at phase_idx 2
        pulse_start();
        check_eq("rs_busy", 64'(busy), 64'd1);
        check_eq("rs_done", 64'(done), 64'd0);
        check_eq("rs_cnt", instr_count, 64'd0);
        check_eq("rs_pe", 64'(phase_en), 64'b00001);
`ifdef SEQ_PERF_COUNTERS_EN
        check_eq("rs_stallcyc", stall_cycles, 64'd0);
`endif
        step(); #1;
        check_eq("st_pe_c2", 64'(phase_en), 64'b00010);
        step();
        stall = 1'b1;
        #1;
        for (int c = 3; c <= 6; c++) begin
            check_eq($sformatf("st_pe_zero_c%0d", c), 64'(phase_en), 64'd0);
            check_eq($sformatf("st_busy_c%0d", c), 64'(busy), 64'd1);
            step();
            if (c == 6) stall = 1'b0;
            #1;
        end
        check_eq("st_pe_c7", 64'(phase_en), 64'b00100);
        step(); #1;
        check_eq("st_pe_c8", 64'(phase_en), 64'b01000);
        check_eq("st_pc_c8", 64'(pc_write_en), 64'd0);
        step(); #1;
        check_eq("st_pc_c9", 64'(pc_write_en), 64'd1);
        check_eq("st_cnt_c9", instr_count, 64'd0);
        step(); #1;
        check_eq("st_cnt_c10", instr_count, 64'd1);
        check_eq("st_pe_c10", 64'(phase_en), 64'b00001);
`ifdef SEQ_PERF_COUNTERS_EN
        check_eq("st_stallcyc", stall_cycles, 64'd4);
`endif

        // Stall on the commit cycle (instruction 2, cycle 14)
        for (int c = 11; c <= 14; c++) step();
        stall = 1'b1;
        #1;
        check_eq("sc_pc", 64'(pc_write_en), 64'd0);
        check_eq("sc_pe", 64'(phase_en), 64'd0);
        check_eq("sc_cnt", instr_count, 64'd1);
        step();
        stall = 1'b0;
        #1;
        check_eq("sc_cnt_hold", instr_count, 64'd1);
        check_eq("sc_pc_rel", 64'(pc_write_en), 64'd1);
        step(); #1;
        check_eq("sc_cnt_after", instr_count, 64'd2);
        check_eq("sc_pe_next", 64'(phase_en), 64'b00001);
        for (int c = 17; c <= 21; c++) step();
        #1;
        check_eq("sc_done", 64'(done), 64'd1);
        check_eq("sc_cnt_end", instr_count, 64'd3);
`ifdef SEQ_PERF_COUNTERS_EN
        check_eq("sc_stallcyc_hold", stall_cycles, 64'd5);
`endif

        // Halt pulsed in phase 1 of instruction 1
        pulse_start();
        step();
        halt_req = 1'b1;
        #1;
        check_eq("h_pe_c2", 64'(phase_en), 64'b00010);
        step();
        halt_req = 1'b0;
        #1;
        check_eq("h_busy_c3", 64'(busy), 64'd1);
        step(); step(); #1;
        check_eq("h_pc_c5", 64'(pc_write_en), 64'd1);
        step(); #1;
        check_eq("h_done", 64'(done), 64'd1);
        check_eq("h_cnt", instr_count, 64'd1);
        check_eq("h_busy", 64'(busy), 64'd0);
        for (int c = 7; c <= 9; c++) begin
            check_eq($sformatf("h_pe_quiet_c%0d", c), 64'(phase_en), 64'd0);
            step(); #1;
        end

        // Reset during phase 3 of instruction 2 (cycle 9)
        pulse_start();
        for (int c = 2; c <= 9; c++) step();
        #1;
        check_eq("r_pe_c9", 64'(phase_en), 64'b01000);
        check_eq("r_cnt_c9", instr_count, 64'd1);
        reset_n = 1'b0;
        #1;
        check_eq("r_pe", 64'(phase_en), 64'd0);
        check_eq("r_cnt", instr_count, 64'd0);
        check_eq("r_busy", 64'(busy), 64'd0);
        check_eq("r_done", 64'(done), 64'd0);
        check_eq("r_pc", 64'(pc_write_en), 64'd0);
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step(); #1;
            check_eq($sformatf("r_idle_busy_%0d", c), 64'(busy), 64'd0);
            check_eq($sformatf("r_idle_pe_%0d", c), 64'(phase_en), 64'd0);
        end
        pulse_start();
        check_eq("r2_busy", 64'(busy), 64'd1);
        check_eq("r2_cnt", instr_count, 64'd0);
        check_eq("r2_pe", 64'(phase_en), 64'b00001);
        for (int c = 2; c <= 6; c++) step();
        #1;
        check_eq("r2_cnt_after", instr_count, 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
- Single-clock phase sequencer for the next-generation LEGv8 datapath top.
- Replaces the chain of delayed clocks with one-hot phase enables: fetch, instr-mem, decode-read, memory, decode-write.
- Adds what the current top lacks: stall, halt request, a parametrised instruction limit and a retired-instruction counter.
- The sequencer sits in the top level; each stage register or memory is clocked by clk and gated by its phase_en bit.

Parameters:
- WORD, 64: width of instr_count.
- NUM_PHASES, 5: phases per instruction; legal range 2..16.
- MAX_INSTR, 20: instructions retired before automatic stop; 0 = unlimited.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  begin or restart execution; sampled in IDLE and DONE.
- stall  input  1  freeze the current phase, e.g. for a multi-cycle memory.
- halt_req  input  1  finish the current instruction, then stop.
- phase_en  output  NUM_PHASES  one-hot enable of the active phase; all zeros when not advancing.
- pc_write_en  output  1  commit strobe; equal to phase_en[NUM_PHASES-1].
- instr_count  output  WORD  instructions retired since the last start.
- busy  output  1  high in RUN.
- done  output  1  high in DONE.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, phase_idx=0, halt_pending=0, instr_count=0.
  - All outputs 0.
  - Reset mid-instruction aborts immediately; there is no partial commit.
- States:
  - IDLE -> RUN on start. phase_idx=0, instr_count=0.
  - RUN: phase_en = onehot(phase_idx) when stall=0, else all zeros.
    - If stall=0 and phase_idx<NUM_PHASES-1, phase_idx increments.
    - If stall=1, all state holds. Stall is ignored outside RUN.
  - Commit cycle: RUN, stall=0, phase_idx=NUM_PHASES-1.
    - pc_write_en=1 for this cycle.
    - At the clock edge, instr_count increments by 1, modulo 2^WORD.
    - Then, if halt_pending, or halt_req is high this cycle, or (MAX_INSTR!=0 and instr_count+1==MAX_INSTR): -> DONE, phase_idx=0, halt_pending=0.
    - Otherwise phase_idx=0 and RUN continues.
  - halt_req high in any non-commit RUN cycle sets halt_pending. It is sticky until DONE.
  - DONE: done=1, instr_count holds.
    - start -> RUN with instr_count=0, phase_idx=0.
  - start in RUN is ignored. halt_req in IDLE or DONE is ignored.
- Outputs are a combinational decode of the registered state plus stall. There is no extra latency.
- First phase_en[0] occurs in the cycle after start is sampled.
- Each instruction takes exactly NUM_PHASES unstalled cycles plus the number of stalled cycles.
- Simultaneous events:
  - stall and halt_req in the same cycle: halt_pending is set, the phase does not advance.
  - stall on the commit cycle: no commit, no count.
  - MAX_INSTR limit and halt on the same commit: single transition to DONE.

Optional Feature:
- Macro: SEQ_PERF_COUNTERS_EN.
- When defined, adds output stall_cycles (WORD bits).
  - Cleared on reset and on every start.
  - Increments on each RUN cycle with stall=1, saturating at all-ones.
  - Holds in DONE.
- When undefined, the port and logic are absent and behaviour is otherwise identical.

Test Plan:
- Run to limit (NUM_PHASES=5, MAX_INSTR=3): start pulse, no stall.
  - phase_en steps 00001..10000 three times.
  - pc_write_en high on cycles 5, 10 and 15 after start.
  - instr_count=3, done=1 on cycle 16, busy=0.
- Stall: stall held for 4 cycles while phase_idx=2.
  - phase_en=0 during those 4 cycles; phase 3 follows.
  - Commit is delayed by exactly 4 cycles.
  - stall_cycles=4 when SEQ_PERF_COUNTERS_EN is defined.
- Halt: halt_req pulsed during phase 1 of instruction 1 (MAX_INSTR=0).
  - That instruction commits; DONE follows with instr_count=1.
  - No phase_en asserts after the commit.
- Stall on the commit cycle: stall=1 with phase_idx=4.
  - pc_write_en=0 and instr_count is unchanged.
  - Releasing stall commits on the next cycle.
- Reset mid-run: reset_n low during phase 3 of instruction 2.
  - All outputs 0 immediately, without waiting for a clock edge.
  - After release, stays in IDLE until start.
  - Restart: instr_count counts from 0.
- Restart from DONE: start in DONE.
  - instr_count clears to 0, busy=1 on the next cycle, phase_en=00001.
